// File: rtl/stream_packer_pkg.sv
// Shared helpers for the stream packer.
// Sizing functions used to derive local widths.
package stream_packer_pkg;

    // Index width, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator lanes: all lanes but the closing one, min one.
    function automatic int acc_lanes(input int n);
        return (n > 1) ? n - 1 : 1;
    endfunction

endpackage

// File: rtl/stream_packer.sv
// Serial-to-parallel packer: PACK_NUM beats into one wide word.
// Optional early close on a last beat with STREAM_PACKER_LAST_EN.
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
`ifdef STREAM_PACKER_LAST_EN
    input  logic                           data_in_last,
    output logic [$clog2(PACK_NUM+1)-1:0]  data_out_count,
`endif
    output logic [PACK_NUM*DATA_WIDTH-1:0] data_out,
    output logic                           data_out_valid,
    input  logic                           data_out_ready
);

    localparam int IDX_WIDTH = idx_bits(PACK_NUM);
    localparam int ACC_W     = acc_lanes(PACK_NUM) * DATA_WIDTH;
    localparam int OUT_W     = PACK_NUM * DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(PACK_NUM + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PACK_NUM - 1);

    logic [IDX_WIDTH-1:0] idx;
    logic [ACC_W-1:0]     acc;
    logic [OUT_W-1:0]     merged;
    logic                 last_beat;
    logic                 closing;
    logic                 accept;

`ifdef STREAM_PACKER_LAST_EN
    logic [CNT_WIDTH-1:0] count_q;
    assign last_beat      = data_in_last;
    assign data_out_count = count_q;
`else
    assign last_beat = 1'b0;
`endif

    // Only a closing beat can stall, and only on a full output register.
    assign closing       = (idx == LAST_IDX) || last_beat;
    assign data_in_ready = !closing || !data_out_valid || data_out_ready;
    assign accept        = data_in_valid && data_in_ready;

    // Collected lanes plus the closing beat at lane idx; upper lanes zero.
    always_comb begin
        merged = '0;
        for (int k = 0; k < PACK_NUM - 1; k++) begin
            merged[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 0; k < PACK_NUM; k++) begin
            if (idx == IDX_WIDTH'(k)) begin
                merged[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end
        end
    end

    // Lane index and partial-word accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            acc <= '0;
        end else if (accept) begin
            if (closing) begin
                idx <= '0;
                acc <= '0;
            end else begin
                idx <= idx + 1'b1;
                for (int k = 0; k < PACK_NUM - 1; k++) begin
                    if (idx == IDX_WIDTH'(k)) begin
                        acc[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                    end
                end
            end
        end
    end

    // Output register: load on closing beat, clear valid on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (accept && closing) begin
            data_out       <= merged;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

`ifdef STREAM_PACKER_LAST_EN
    // Lane count travels with the word it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accept && closing) begin
            count_q <= CNT_WIDTH'(idx) + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
